// File: rtl/wb_txn_pkg.sv
// Shared types and constants for the Wishbone transaction engine.
// Holds FSM encoding, response status codes and cycle-type codes.
package wb_txn_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT,
    S_HOLD,
    S_FLUSH
  } state_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ERR   = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_FLUSH = 2'b11;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_txn_fifo.sv
// Synchronous show-ahead command FIFO.
// Head is visible on dout whenever empty is low.
module wb_txn_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign dout  = mem[rp];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_txn_engine.sv
// Queued Wishbone master: FIFO of beats, burst FSM, ordered responses.
// A one-entry skid behind the response register absorbs a late stall.
module wb_txn_engine
  import wb_txn_pkg::*;
#(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk48,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic            cmd_last,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic [1:0]      rsp_status,
  output logic [AW-1:0]   wishbone_adr,
  output logic [DW-1:0]   wishbone_datwr,
  input  logic [DW-1:0]   wishbone_datrd,
  output logic [DW/8-1:0] wishbone_sel,
  output logic            wishbone_cyc,
  output logic            wishbone_stb,
  output logic            wishbone_we,
  output logic [2:0]      wishbone_cti,
  output logic [1:0]      wishbone_bte,
  input  logic            wishbone_ack,
  input  logic            wishbone_err,
  output logic [7:0]      err_count
);

  localparam int SW = DW / 8;
  localparam int CW = AW + DW + SW + 2;
  localparam int NW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  state_t state;
  state_t state_nx;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [NW-1:0] count;
  logic [CW-1:0] head;

  logic          h_we;
  logic          h_last;
  logic [SW-1:0] h_sel;
  logic [DW-1:0] h_dat;
  logic [AW-1:0] h_adr;

  logic [TW-1:0] wait_cnt;
  logic          wait_inc;

  logic          sk_valid;
  logic [DW-1:0] sk_dat;
  logic [1:0]    sk_status;

  logic          ld;
  logic [DW-1:0] ld_dat;
  logic [1:0]    ld_status;
  logic          bump;

  logic          start_ok;
  logic          more;
  logic          cont;
  logic          room;

  assign push      = cmd_valid && !full;
  assign cmd_ready = !full;

  wb_txn_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk48),
    .reset (reset),
    .push  (push),
    .din   ({cmd_we, cmd_last, cmd_sel, cmd_dat, cmd_adr}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign {h_we, h_last, h_sel, h_dat, h_adr} = head;

  // a beat may only start once its response is guaranteed a slot
  assign start_ok = !empty && (!rsp_valid || rsp_ready);
  assign more     = (count > NW'(1)) || push;
  assign cont     = more && rsp_ready && !sk_valid;
  assign room     = !sk_valid || rsp_ready;

  assign wishbone_bte = 2'b00;

  always_ff @(posedge clk48) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      err_count <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_inc ? wait_cnt + TW'(1) : '0;
      if (bump) err_count <= sat_inc(err_count);
    end
  end

  always_ff @(posedge clk48) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_status <= ST_OK;
      sk_valid   <= 1'b0;
      sk_dat     <= '0;
      sk_status  <= ST_OK;
    end else if (!rsp_valid || rsp_ready) begin
      if (sk_valid) begin
        rsp_valid  <= 1'b1;
        rsp_dat    <= sk_dat;
        rsp_status <= sk_status;
        sk_valid   <= ld;
        if (ld) begin
          sk_dat    <= ld_dat;
          sk_status <= ld_status;
        end
      end else begin
        rsp_valid <= ld;
        if (ld) begin
          rsp_dat    <= ld_dat;
          rsp_status <= ld_status;
        end
      end
    end else if (ld) begin
      sk_valid  <= 1'b1;
      sk_dat    <= ld_dat;
      sk_status <= ld_status;
    end
  end

  always_comb begin
    state_nx       = state;
    pop            = 1'b0;
    ld             = 1'b0;
    ld_dat         = '0;
    ld_status      = ST_OK;
    bump           = 1'b0;
    wait_inc       = 1'b0;
    wishbone_cyc   = 1'b0;
    wishbone_stb   = 1'b0;
    wishbone_we    = 1'b0;
    wishbone_adr   = '0;
    wishbone_datwr = '0;
    wishbone_sel   = '0;
    wishbone_cti   = CTI_CLASSIC;
    unique case (state)
      S_IDLE: begin
        if (start_ok) state_nx = S_BEAT;
      end
      S_BEAT: begin
        wishbone_cyc   = 1'b1;
        wishbone_stb   = 1'b1;
        wishbone_we    = h_we;
        wishbone_adr   = h_adr;
        wishbone_datwr = h_dat;
        wishbone_sel   = h_sel;
        wishbone_cti   = h_last ? CTI_EOB : CTI_INCR;
        unique case (1'b1)
          wishbone_err: begin
            pop       = 1'b1;
            ld        = 1'b1;
            ld_status = ST_ERR;
            bump      = 1'b1;
            state_nx  = h_last ? S_IDLE : S_FLUSH;
          end
          wishbone_ack: begin
            pop    = 1'b1;
            ld     = 1'b1;
            ld_dat = h_we ? '0 : wishbone_datrd;
            if (h_last)    state_nx = S_IDLE;
            else if (cont) state_nx = S_BEAT;
            else           state_nx = S_HOLD;
          end
          (wait_cnt == TLIM): begin
            pop       = 1'b1;
            ld        = 1'b1;
            ld_status = ST_TMO;
            bump      = 1'b1;
            state_nx  = h_last ? S_IDLE : S_FLUSH;
          end
          default: wait_inc = 1'b1;
        endcase
      end
      S_HOLD: begin
        wishbone_cyc = 1'b1;
        if (start_ok) state_nx = S_BEAT;
      end
      S_FLUSH: begin
        if (!empty && room) begin
          pop       = 1'b1;
          ld        = 1'b1;
          ld_status = ST_FLUSH;
          if (h_last) state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
